pulse_len_monitor: RTL and testbench
====================================

// Module: pulse_len_monitor
// PURPOSE
//  Downstream checker for the 3-cycle-high Moore FSM output. Watches the FSM's
//  y line, measures the length of every high pulse, and classifies it against
//  an expected length. Keeps saturating good/bad pulse counters and flags a
//  line stuck high. Sits in the same clock domain as the FSM; y_in is
//  registered/glitch-free, so no synchronizer is used.
// PARAMETERS
//  LEN_W    4  width of pulse length counter; MAX_LEN = 2**LEN_W-1
//  EXP_LEN  3  pulse length (cycles) classified as good; 1..MAX_LEN-1
//  CNT_W    8  width of ok/err event counters
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      reset; synchronous, active-high
//  y_in        in   1      monitored line (FSM output y)
//  clr_counts  in   1      synchronous clear of ok_count/err_count
//  pulse_valid out  1      1-cycle strobe: a pulse just ended
//  pulse_len   out  LEN_W  length of that pulse; held until next strobe
//  len_ok      out  1      pulse_len==EXP_LEN; held with pulse_len
//  stuck_high  out  1      high while in STUCK state
//  ok_count    out  CNT_W  number of good pulses; saturating
//  err_count   out  CNT_W  number of bad pulses; saturating
// BEHAVIOUR
//  Reset: state=IDLE, len_cnt=0, all outputs 0. Applies to all regs on any
//   cycle, including mid-pulse; a pulse in progress is discarded, no strobe.
//  y_in is sampled on every rising clk. All outputs are registered.
//  States:
//   IDLE:  y_in=1 -> HIGH, len_cnt<=1.  y_in=0 -> stay.
//   HIGH:  y_in=1 and len_cnt<MAX_LEN-1 -> len_cnt+1, stay.
//          y_in=1 and len_cnt==MAX_LEN-1 -> len_cnt<=MAX_LEN, STUCK.
//          y_in=0 -> IDLE; end-of-pulse event with L=len_cnt.
//   STUCK: stuck_high=1. y_in=1 -> stay, len_cnt held at MAX_LEN.
//          y_in=0 -> IDLE, stuck_high<=0; end-of-pulse event, L=MAX_LEN.
//  End-of-pulse event, on the edge where y_in is first sampled 0:
//   pulse_valid<=1 for exactly one cycle; pulse_len<=L;
//   len_ok<=(L==EXP_LEN). A STUCK pulse is never ok.
//   ok_count+1 if ok, else err_count+1. Both saturate at 2**CNT_W-1, no wrap.
//  Latency: pulse_valid is high in the cycle after the first low sample.
//   Good EXP_LEN=3 pulse: high at edges t..t+2, low at t+3 -> strobe in
//   cycle t+3..t+4.
//  Back-to-back: one low cycle between pulses is sufficient. The strobe for
//   pulse n and the HIGH entry for pulse n+1 never collide.
//  A pulse high at the first edge after reset is measured from that edge.
//   It is a partial pulse and normally counts as an error.
//  clr_counts=1 zeroes both counters and wins over a coincident event.
//   That event still strobes pulse_valid/pulse_len/len_ok but is not counted.
//  pulse_len/len_ok hold their last value between strobes.
// TESTING (EXP_LEN=3, LEN_W=4, CNT_W=8 unless noted)
//  1 y_in high 3 cycles then low -> one pulse_valid, pulse_len=3, len_ok=1,
//    ok_count=1, err_count=0.
//  2 y_in high 2 cycles, then 4 -> two strobes: len 2 then 4, len_ok=0 both;
//    err_count=2.
//  3 y_in high 20 cycles -> stuck_high rises after 15th high sample and
//    stays 1; on low: pulse_len=15, len_ok=0, err_count+1, stuck_high=0.
//  4 Drive real FSM (x=1) for 4 triggers: pattern 0,1,1,1 repeated ->
//    4 strobes 4 cycles apart, ok_count=4.
//  5 CNT_W=2: 5 good pulses -> ok_count 1,2,3,3,3. clr_counts coincident
//    with 6th strobe -> ok_count=0, strobe still seen.
//  6 rst mid-pulse (after 2 highs, y_in stays high 3 more) -> no strobe at
//    reset, counters 0; next strobe pulse_len=3.

Source files
------------

// File: rtl/pulse_len_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_len_monitor
//  Description : Measures the length of every high pulse on y_in, classifies
//                it against EXP_LEN, keeps saturating good/bad pulse counters
//                and flags a line that stays high for MAX_LEN or more cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_len_monitor #(
    parameter int LEN_W   = 4,
    parameter int EXP_LEN = 3,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             y_in,
    input  logic             clr_counts,
    output logic             pulse_valid,
    output logic [LEN_W-1:0] pulse_len,
    output logic             len_ok,
    output logic             stuck_high,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] err_count
);

    // Longest measurable pulse; reaching it means the line is stuck high.
    localparam logic [LEN_W-1:0] MAX_LEN     = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] MAX_LEN_M1  = MAX_LEN - 1'b1;
    localparam logic [LEN_W-1:0] LEN_ONE     = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] EXP_LEN_C   = LEN_W'(EXP_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HIGH  = 2'd1,
        S_STUCK = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_cnt_q, len_cnt_d;
    logic               stuck_q, stuck_d;
    logic               pulse_valid_q, pulse_valid_d;
    logic [LEN_W-1:0]   pulse_len_q, pulse_len_d;
    logic               len_ok_q, len_ok_d;
    logic [CNT_W-1:0]   ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    // End-of-pulse event decoded by the FSM in the cycle y_in is seen low.
    logic               pulse_end;
    logic [LEN_W-1:0]   end_len;
    logic               end_ok;

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            len_cnt_q     <= '0;
            stuck_q       <= 1'b0;
            pulse_valid_q <= 1'b0;
            pulse_len_q   <= '0;
            len_ok_q      <= 1'b0;
            ok_cnt_q      <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            len_cnt_q     <= len_cnt_d;
            stuck_q       <= stuck_d;
            pulse_valid_q <= pulse_valid_d;
            pulse_len_q   <= pulse_len_d;
            len_ok_q      <= len_ok_d;
            ok_cnt_q      <= ok_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    // Next-state logic: track the current pulse length and detect its end.
    always_comb begin
        state_d   = state_q;
        len_cnt_d = len_cnt_q;
        stuck_d   = stuck_q;
        pulse_end = 1'b0;
        end_len   = '0;
        end_ok    = 1'b0;
        case (state_q)
            S_IDLE: begin
                stuck_d = 1'b0;
                if (y_in) begin
                    state_d   = S_HIGH;
                    len_cnt_d = LEN_ONE;
                end
            end
            S_HIGH: begin
                if (y_in) begin
                    if (len_cnt_q == MAX_LEN_M1) begin
                        // Saturate the length and flag the line as stuck.
                        state_d   = S_STUCK;
                        len_cnt_d = MAX_LEN;
                        stuck_d   = 1'b1;
                    end else begin
                        len_cnt_d = len_cnt_q + 1'b1;
                    end
                end else begin
                    state_d   = S_IDLE;
                    len_cnt_d = '0;
                    pulse_end = 1'b1;
                    end_len   = len_cnt_q;
                    end_ok    = (len_cnt_q == EXP_LEN_C);
                end
            end
            S_STUCK: begin
                len_cnt_d = MAX_LEN;
                stuck_d   = 1'b1;
                if (!y_in) begin
                    // A stuck pulse is reported at full scale and never good.
                    state_d   = S_IDLE;
                    len_cnt_d = '0;
                    stuck_d   = 1'b0;
                    pulse_end = 1'b1;
                    end_len   = MAX_LEN;
                    end_ok    = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                len_cnt_d = '0;
                stuck_d   = 1'b0;
            end
        endcase
    end

    // Result and counter update: strobe, hold length/ok, saturating counts.
    always_comb begin
        pulse_valid_d = pulse_end;
        pulse_len_d   = pulse_len_q;
        len_ok_d      = len_ok_q;
        ok_cnt_d      = ok_cnt_q;
        err_cnt_d     = err_cnt_q;
        if (pulse_end) begin
            pulse_len_d = end_len;
            len_ok_d    = end_ok;
        end
        if (clr_counts) begin
            // Clear wins: a coincident event still strobes but is not counted.
            ok_cnt_d  = '0;
            err_cnt_d = '0;
        end else if (pulse_end) begin
            if (end_ok) begin
                if (ok_cnt_q != CNT_MAX) begin
                    ok_cnt_d = ok_cnt_q + 1'b1;
                end
            end else begin
                if (err_cnt_q != CNT_MAX) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end
    end

    assign pulse_valid = pulse_valid_q;
    assign pulse_len   = pulse_len_q;
    assign len_ok      = len_ok_q;
    assign stuck_high  = stuck_q;
    assign ok_count    = ok_cnt_q;
    assign err_count   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_len_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_len_monitor
//  Description : Directed self-checking bench for pulse_len_monitor. A second
//                instance with a 2-bit counter exercises saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pulse_len_monitor;

    logic       clk;
    logic       rst;
    logic       y_in;
    logic       clr_counts;

    logic       pv1, ok1b, st1;
    logic [3:0] len1;
    logic [7:0] okc1, errc1;

    logic       pv2, ok2b, st2;
    logic [3:0] len2;
    logic [1:0] okc2, errc2;

    int checks;
    int fails;

    pulse_len_monitor #(.LEN_W(4), .EXP_LEN(3), .CNT_W(8)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .y_in        (y_in),
        .clr_counts  (clr_counts),
        .pulse_valid (pv1),
        .pulse_len   (len1),
        .len_ok      (ok1b),
        .stuck_high  (st1),
        .ok_count    (okc1),
        .err_count   (errc1)
    );

    pulse_len_monitor #(.LEN_W(4), .EXP_LEN(3), .CNT_W(2)) u_dut2 (
        .clk         (clk),
        .rst         (rst),
        .y_in        (y_in),
        .clr_counts  (clr_counts),
        .pulse_valid (pv2),
        .pulse_len   (len2),
        .len_ok      (ok2b),
        .stuck_high  (st2),
        .ok_count    (okc2),
        .err_count   (errc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, take one rising edge, then settle before sampling.
    task automatic step(input logic y, input logic clr);
        y_in       = y;
        clr_counts = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic highs(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if ({pv1, len1, ok1b, st1, okc1, errc1} !== 23'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", {pv1, len1, ok1b, st1, okc1, errc1});
        end
        checks++;
        if ({pv2, len2, ok2b, st2, okc2, errc2} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs2: got %h expected 0", {pv2, len2, ok2b, st2, okc2, errc2});
        end
        rst = 1'b0;
        step(1'b0, 1'b0);
    endtask

    task automatic test_good_pulse();
        do_reset();
        highs(3);
        checks++;
        if (pv1 !== 1'b0) begin
            fails++;
            $display("FAIL good_no_early_strobe: got %b expected 0", pv1);
        end
        step(1'b0, 1'b0);
        checks++;
        if ({pv1, len1, ok1b, okc1, errc1} !== {1'b1, 4'd3, 1'b1, 8'd1, 8'd0}) begin
            fails++;
            $display("FAIL good_pulse: got pv=%b len=%0d ok=%b okc=%0d errc=%0d expected 1 3 1 1 0",
                     pv1, len1, ok1b, okc1, errc1);
        end
        step(1'b0, 1'b0);
        checks++;
        if ({pv1, len1, ok1b} !== {1'b0, 4'd3, 1'b1}) begin
            fails++;
            $display("FAIL good_hold: got pv=%b len=%0d ok=%b expected 0 3 1", pv1, len1, ok1b);
        end
    endtask

    task automatic test_bad_pulses();
        do_reset();
        highs(2);
        step(1'b0, 1'b0);
        checks++;
        if ({pv1, len1, ok1b, okc1, errc1} !== {1'b1, 4'd2, 1'b0, 8'd0, 8'd1}) begin
            fails++;
            $display("FAIL bad_len2: got pv=%b len=%0d ok=%b okc=%0d errc=%0d expected 1 2 0 0 1",
                     pv1, len1, ok1b, okc1, errc1);
        end
        highs(4);
        step(1'b0, 1'b0);
        checks++;
        if ({pv1, len1, ok1b, okc1, errc1} !== {1'b1, 4'd4, 1'b0, 8'd0, 8'd2}) begin
            fails++;
            $display("FAIL bad_len4: got pv=%b len=%0d ok=%b okc=%0d errc=%0d expected 1 4 0 0 2",
                     pv1, len1, ok1b, okc1, errc1);
        end
    endtask

    task automatic test_stuck();
        do_reset();
        highs(14);
        checks++;
        if ({st1, pv1} !== 2'b00) begin
            fails++;
            $display("FAIL stuck_early: got st=%b pv=%b expected 0 0", st1, pv1);
        end
        highs(1);
        checks++;
        if ({st1, pv1} !== 2'b10) begin
            fails++;
            $display("FAIL stuck_rise: got st=%b pv=%b expected 1 0", st1, pv1);
        end
        highs(5);
        checks++;
        if ({st1, pv1} !== 2'b10) begin
            fails++;
            $display("FAIL stuck_hold: got st=%b pv=%b expected 1 0", st1, pv1);
        end
        step(1'b0, 1'b0);
        checks++;
        if ({pv1, len1, ok1b, st1, okc1, errc1} !== {1'b1, 4'd15, 1'b0, 1'b0, 8'd0, 8'd1}) begin
            fails++;
            $display("FAIL stuck_end: got pv=%b len=%0d ok=%b st=%b okc=%0d errc=%0d expected 1 15 0 0 0 1",
                     pv1, len1, ok1b, st1, okc1, errc1);
        end
    endtask

    // Emulates the 3-cycle FSM with x=1: pattern 0,1,1,1 repeated.
    task automatic test_back_to_back();
        logic exp_pv;
        int   strobes;
        do_reset();
        strobes = 0;
        for (int k = 0; k < 17; k++) begin
            step((k % 4) != 0, 1'b0);
            exp_pv = (k != 0) && ((k % 4) == 0);
            if (pv1) strobes++;
            checks++;
            if (pv1 !== exp_pv) begin
                fails++;
                $display("FAIL b2b_strobe_k%0d: got %b expected %b", k, pv1, exp_pv);
            end
        end
        checks++;
        if ({strobes[7:0], okc1, errc1, len1} !== {8'd4, 8'd4, 8'd0, 4'd3}) begin
            fails++;
            $display("FAIL b2b_counts: got strobes=%0d okc=%0d errc=%0d len=%0d expected 4 4 0 3",
                     strobes, okc1, errc1, len1);
        end
    endtask

    task automatic test_saturate_clear();
        logic [1:0] exp_ok;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            highs(3);
            step(1'b0, 1'b0);
            exp_ok = (i >= 3) ? 2'd3 : 2'(i);
            checks++;
            if ({pv2, okc2, errc2} !== {1'b1, exp_ok, 2'd0}) begin
                fails++;
                $display("FAIL sat_pulse%0d: got pv=%b okc=%0d errc=%0d expected 1 %0d 0",
                         i, pv2, okc2, errc2, exp_ok);
            end
        end
        checks++;
        if (okc1 !== 8'd5) begin
            fails++;
            $display("FAIL sat_wide_count: got %0d expected 5", okc1);
        end
        highs(3);
        step(1'b0, 1'b1);
        checks++;
        if ({pv2, len2, ok2b, okc2, errc2} !== {1'b1, 4'd3, 1'b1, 2'd0, 2'd0}) begin
            fails++;
            $display("FAIL clr_coincident: got pv=%b len=%0d ok=%b okc=%0d errc=%0d expected 1 3 1 0 0",
                     pv2, len2, ok2b, okc2, errc2);
        end
        checks++;
        if ({pv1, okc1} !== {1'b1, 8'd0}) begin
            fails++;
            $display("FAIL clr_coincident_wide: got pv=%b okc=%0d expected 1 0", pv1, okc1);
        end
        step(1'b0, 1'b0);
        checks++;
        if ({pv2, okc2, okc1} !== {1'b0, 2'd0, 8'd0}) begin
            fails++;
            $display("FAIL clr_after: got pv=%b okc2=%0d okc1=%0d expected 0 0 0", pv2, okc2, okc1);
        end
    endtask

    task automatic test_reset_mid_pulse();
        do_reset();
        highs(2);
        rst = 1'b1;
        step(1'b1, 1'b0);
        rst = 1'b0;
        checks++;
        if ({pv1, len1, okc1, errc1, st1} !== {1'b0, 4'd0, 8'd0, 8'd0, 1'b0}) begin
            fails++;
            $display("FAIL rst_mid: got pv=%b len=%0d okc=%0d errc=%0d st=%b expected 0 0 0 0 0",
                     pv1, len1, okc1, errc1, st1);
        end
        highs(3);
        checks++;
        if (pv1 !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_nostrobe: got %b expected 0", pv1);
        end
        step(1'b0, 1'b0);
        checks++;
        if ({pv1, len1, ok1b, okc1} !== {1'b1, 4'd3, 1'b1, 8'd1}) begin
            fails++;
            $display("FAIL rst_mid_next: got pv=%b len=%0d ok=%b okc=%0d expected 1 3 1 1",
                     pv1, len1, ok1b, okc1);
        end
    endtask

    initial begin
        checks     = 0;
        fails      = 0;
        rst        = 1'b1;
        y_in       = 1'b0;
        clr_counts = 1'b0;
        test_reset();
        test_good_pulse();
        test_bad_pulses();
        test_stuck();
        test_back_to_back();
        test_saturate_clear();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
